// File: rtl/delay_protocol_sequencer.sv
// delay_protocol_sequencer
//
// Steps the delay/pulse generator through a table of up to NPROTOCOLS protocols.
// Each protocol is a full set of NDELAY_CHANNELS delay/width pairs plus a
// replicate count. Every protocol change is handed to the generator so that it
// takes effect on a t0 boundary and lasts exactly that protocol's replicate
// count of periods.
//
// Optional feature: define DELAY_SEQ_LOOP_EN to wrap from the last active
// protocol back to protocol 0 forever. When it is not defined, the block stops
// in DONE once the last protocol has run all of its periods.
//
// Ports
//   clk_i                    system clock
//   reset_ni                 asynchronous active-low reset
//   cfg_wr_i                 table write strobe: table[cfg_proto_i][cfg_chan_i] <= cfg_pair_i
//   cfg_proto_i              protocol index for table/replicate writes
//   cfg_chan_i               channel index for table writes
//   cfg_pair_i               delay/width pair, packed as {delay, width}
//   cfg_rep_wr_i             replicate write strobe: rep[cfg_proto_i] <= cfg_rep_i
//   cfg_rep_i                periods per protocol (0 behaves as 1)
//   cfg_nprotocols_i         active protocol count (0 behaves as 1)
//   run_i                    level: high runs, low aborts
//   tp0_i                    generator t0 pulse, one clock wide
//   user_delay_width_pairs_o registered pairs presented to the generator
//   user_data_valid_o        load request to the generator
//   protocol_index_o         protocol currently presented or armed
//   busy_o                   high in ARM or RUN
//   done_o                   high in DONE

module delay_protocol_sequencer #(
    parameter int unsigned NDELAY_CHANNELS = 9,
    parameter int unsigned NPROTOCOLS      = 4,
    parameter int unsigned WIDTH           = 32,
    localparam int unsigned PW = (NPROTOCOLS > 1) ? $clog2(NPROTOCOLS) : 1,
    localparam int unsigned CW = (NDELAY_CHANNELS > 1) ? $clog2(NDELAY_CHANNELS) : 1
) (
    input  logic                                        clk_i,
    input  logic                                        reset_ni,
    input  logic                                        cfg_wr_i,
    input  logic [PW-1:0]                               cfg_proto_i,
    input  logic [CW-1:0]                               cfg_chan_i,
    input  logic [2*WIDTH-1:0]                          cfg_pair_i,
    input  logic                                        cfg_rep_wr_i,
    input  logic [WIDTH-1:0]                            cfg_rep_i,
    input  logic [PW:0]                                 cfg_nprotocols_i,
    input  logic                                        run_i,
    input  logic                                        tp0_i,
    output logic [NDELAY_CHANNELS-1:0][2*WIDTH-1:0]     user_delay_width_pairs_o,
    output logic                                        user_data_valid_o,
    output logic [PW-1:0]                               protocol_index_o,
    output logic                                        busy_o,
    output logic                                        done_o
);

    typedef enum logic [1:0] {StIdle, StArm, StRun, StDone} state_e;

    state_e                                     state_q, state_d;
    logic [NDELAY_CHANNELS-1:0][2*WIDTH-1:0]    table_q [NPROTOCOLS];
    logic [WIDTH-1:0]                           rep_q   [NPROTOCOLS];
    logic [NDELAY_CHANNELS-1:0][2*WIDTH-1:0]    pairs_q, pairs_d;
    logic                                       valid_q, valid_d;
    logic [PW-1:0]                              index_q, index_d;
    logic [WIDTH-1:0]                           count_q, count_d;
    // Last protocol has started its final period; leave for DONE at the next t0.
    logic                                       final_q, final_d;

    logic [WIDTH-1:0]                           rep_eff;
    logic [WIDTH:0]                             count_inc;
    logic [PW:0]                                nprot_eff;
    logic [PW:0]                                next_idx;
    logic                                       last_period;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            pairs_q <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            count_q <= '0;
            final_q <= 1'b0;
            for (int p = 0; p < int'(NPROTOCOLS); p++) begin
                table_q[p] <= '0;
                rep_q[p]   <= '0;
            end
        end else begin
            state_q <= state_d;
            pairs_q <= pairs_d;
            valid_q <= valid_d;
            index_q <= index_d;
            count_q <= count_d;
            final_q <= final_d;
            // Loads read table_q, so a same-edge write is seen only on a later load.
            if (cfg_wr_i && (32'(cfg_chan_i) < NDELAY_CHANNELS)) begin
                table_q[cfg_proto_i][cfg_chan_i] <= cfg_pair_i;
            end
            if (cfg_rep_wr_i) begin
                rep_q[cfg_proto_i] <= cfg_rep_i;
            end
        end
    end

    always_comb begin
        rep_eff   = (rep_q[index_q] == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : rep_q[index_q];
        count_inc = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
        next_idx  = {1'b0, index_q} + (PW+1)'(1);
        if (cfg_nprotocols_i == '0) begin
            nprot_eff = (PW+1)'(1);
        end else if (cfg_nprotocols_i > (PW+1)'(NPROTOCOLS)) begin
            nprot_eff = (PW+1)'(NPROTOCOLS);
        end else begin
            nprot_eff = cfg_nprotocols_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        pairs_d     = pairs_q;
        valid_d     = valid_q;
        index_d     = index_q;
        count_d     = count_q;
        final_d     = final_q;
        last_period = 1'b0;

        case (state_q)
            StIdle: begin
                if (run_i) begin
                    index_d = '0;
                    pairs_d = table_q[0];
                    valid_d = 1'b1;
                    final_d = 1'b0;
                    state_d = StArm;
                end
            end
            StArm: begin
                if (!run_i) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    index_d = '0;
                    final_d = 1'b0;
                end else if (tp0_i) begin
                    // The generator latches on this t0: period 1 of this protocol.
                    valid_d     = 1'b0;
                    count_d     = {{(WIDTH-1){1'b0}}, 1'b1};
                    state_d     = StRun;
                    last_period = (rep_eff == {{(WIDTH-1){1'b0}}, 1'b1});
                end
            end
            StRun: begin
                if (!run_i) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    index_d = '0;
                    final_d = 1'b0;
                end else if (tp0_i) begin
                    if (final_q) begin
                        state_d = StDone;
                    end else begin
                        // Widened compare so rep = 2^WIDTH-1 cannot wrap.
                        count_d     = count_inc[WIDTH-1:0];
                        last_period = (count_inc == {1'b0, rep_eff});
                    end
                end
            end
            StDone: begin
                if (!run_i) begin
                    state_d = StIdle;
                    index_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // The period just started is the last one for this protocol: present the
        // next one now so the generator picks it up at the following t0.
        if (last_period) begin
            if (next_idx >= nprot_eff) begin
`ifdef DELAY_SEQ_LOOP_EN
                index_d = '0;
                pairs_d = table_q[0];
                valid_d = 1'b1;
                state_d = StArm;
`else
                final_d = 1'b1;
                state_d = StRun;
`endif
            end else begin
                index_d = next_idx[PW-1:0];
                pairs_d = table_q[next_idx[PW-1:0]];
                valid_d = 1'b1;
                state_d = StArm;
            end
        end
    end

    assign user_delay_width_pairs_o = pairs_q;
    assign user_data_valid_o        = valid_q;
    assign protocol_index_o         = index_q;
    assign busy_o                   = (state_q == StArm) || (state_q == StRun);
    assign done_o                   = (state_q == StDone);

endmodule

// File: tb/tb_delay_protocol_sequencer.sv
// Bench for delay_protocol_sequencer: free-running t0 source (interval 9), a
// generator latch model, table-driven protocol sequences checked through a
// scoreboard queue, and hand-written reset / write / abort sequences.

module tb_delay_protocol_sequencer;

    localparam int NCH      = 9;
    localparam int NP       = 4;
    localparam int W        = 32;
    localparam int INTERVAL = 9;
`ifdef DELAY_SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         reset_n;
    logic                         cfg_wr;
    logic [1:0]                   cfg_proto;
    logic [3:0]                   cfg_chan;
    logic [63:0]                  cfg_pair;
    logic                         cfg_rep_wr;
    logic [31:0]                  cfg_rep;
    logic [2:0]                   cfg_nprot;
    logic                         run;
    logic                         tp0;
    logic [NCH-1:0][63:0]         pairs;
    logic                         valid;
    logic [1:0]                   pindex;
    logic                         busy;
    logic                         done;

    delay_protocol_sequencer #(
        .NDELAY_CHANNELS(NCH),
        .NPROTOCOLS     (NP),
        .WIDTH          (W)
    ) dut (
        .clk_i                   (clk),
        .reset_ni                (reset_n),
        .cfg_wr_i                (cfg_wr),
        .cfg_proto_i             (cfg_proto),
        .cfg_chan_i              (cfg_chan),
        .cfg_pair_i              (cfg_pair),
        .cfg_rep_wr_i            (cfg_rep_wr),
        .cfg_rep_i               (cfg_rep),
        .cfg_nprotocols_i        (cfg_nprot),
        .run_i                   (run),
        .tp0_i                   (tp0),
        .user_delay_width_pairs_o(pairs),
        .user_data_valid_o       (valid),
        .protocol_index_o        (pindex),
        .busy_o                  (busy),
        .done_o                  (done)
    );

    always #5 clk = ~clk;

    // Free-running t0 source and generator latch model.
    int gcnt = 0;
    logic [NCH-1:0][63:0] gen_pairs = '0;
    always @(posedge clk) gcnt <= (gcnt == INTERVAL - 1) ? 0 : gcnt + 1;
    assign tp0 = (gcnt == 0);
    always @(posedge clk) if (tp0 && valid) gen_pairs <= pairs;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_ch0[NP];
    logic [63:0] exp_ch3[NP];

    typedef struct packed {
        logic [2:0]       nprot;
        logic [3:0][31:0] rep;
        logic [3:0]       nexp;
        logic [7:0][1:0]  seq;
        logic             chk_valid;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [63:0] pr(input int d, input int w);
        return {32'(d), 32'(w)};
    endfunction

    function automatic vec_t mk(input int np, input int r0, input int r1, input int r2,
                                input int r3, input int n, input int s0, input int s1,
                                input int s2, input int s3, input int s4, input int s5,
                                input bit cv);
        vec_t v;
        v = '0;
        v.nprot = 3'(np);
        v.rep[0] = 32'(r0); v.rep[1] = 32'(r1); v.rep[2] = 32'(r2); v.rep[3] = 32'(r3);
        v.nexp = 4'(n);
        v.seq[0] = 2'(s0); v.seq[1] = 2'(s1); v.seq[2] = 2'(s2);
        v.seq[3] = 2'(s3); v.seq[4] = 2'(s4); v.seq[5] = 2'(s5);
        v.chk_valid = cv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns just after the next t0 edge; seen_valid is valid as sampled at it.
    task automatic wait_t0(output bit seen_valid);
        bit found;
        found = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 2 * INTERVAL + 2; i++) begin
            @(negedge clk);
            if (tp0) begin
                seen_valid = valid;
                @(posedge clk);
                #1;
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("t0_timeout", 64'd0, 64'd1);
    endtask

    task automatic wr_pair(input int p, input int c, input logic [63:0] v);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_proto = 2'(p); cfg_chan = 4'(c); cfg_pair = v;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic wr_rep(input int p, input int r);
        @(negedge clk);
        cfg_rep_wr = 1'b1; cfg_proto = 2'(p); cfg_rep = 32'(r);
        @(negedge clk);
        cfg_rep_wr = 1'b0;
    endtask

    task automatic load_table();
        for (int p = 0; p < NP; p++) begin
            wr_pair(p, 0, exp_ch0[p]);
            wr_pair(p, 3, exp_ch3[p]);
        end
    endtask

    // Start run just after a t0 so valid is up well before the next one.
    task automatic start_run();
        bit sv;
        wait_t0(sv);
        @(negedge clk);
        run = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sv;
        bit any_valid;
        logic [63:0] exp_pair;

        exp_ch0[0] = pr(5, 3);  exp_ch0[1] = pr(20, 4);
        exp_ch0[2] = pr(7, 1);  exp_ch0[3] = pr(11, 2);
        for (int p = 0; p < NP; p++) exp_ch3[p] = pr(100 + p, 1);

        vecs[0] = mk(2, 2, 3, 1, 1, 6, 0, 0, 1, 1, 1, LOOP ? 0 : 1, 1'b0);
        vecs[1] = mk(4, 1, 1, 1, 1, 5, 0, 1, 2, 3, LOOP ? 0 : 3, 0, 1'b1);
        vecs[2] = mk(0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1'b1);
        vecs[3] = mk(2, 0, 0, 1, 1, 3, 0, 1, LOOP ? 0 : 1, 0, 0, 0, 1'b1);
        vecs[4] = mk(3, 1, 2, 1, 1, 5, 0, 1, 1, 2, LOOP ? 0 : 2, 0, 1'b0);

        reset_n = 1'b0; cfg_wr = 1'b0; cfg_proto = '0; cfg_chan = '0; cfg_pair = '0;
        cfg_rep_wr = 1'b0; cfg_rep = '0; cfg_nprot = 3'd1; run = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_index", 64'(pindex), 64'd0);
        chk("rst_pairs_zero", 64'(pairs != '0), 64'd0);

        // Reset while armed.
        load_table();
        start_run();
        @(negedge clk);
        chk("run_to_valid", 64'(valid), 64'd1);
        chk("arm_busy", 64'(busy), 64'd1);
        chk("arm_pair0", pairs[0], exp_ch0[0]);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid), 64'd0);
        chk("midrst_pairs_zero", 64'(pairs != '0), 64'd0);
        tick(2);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_index", 64'(pindex), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("postrst_valid", 64'(valid), 64'd1);
        run = 1'b0;
        tick(2);

        // Same-edge write and load of protocol 0 ch0: load sees the old value.
        load_table();
        @(negedge clk);
        run = 1'b1; cfg_wr = 1'b1; cfg_proto = 2'd0; cfg_chan = 4'd0; cfg_pair = pr(55, 5);
        @(negedge clk);
        cfg_wr = 1'b0;
        chk("same_edge_old", pairs[0], exp_ch0[0]);
        run = 1'b0;
        tick(2);
        run = 1'b1;
        @(negedge clk);
        chk("same_edge_new_later", pairs[0], pr(55, 5));
        run = 1'b0;
        wr_pair(0, 0, exp_ch0[0]);

        // Table-driven protocol sequences, scoreboarded per t0 period.
        for (int v = 0; v < 5; v++) begin
            run = 1'b0;
            tick(2);
            for (int p = 0; p < NP; p++) wr_rep(p, int'(vecs[v].rep[p]));
            cfg_nprot = vecs[v].nprot;
            sb_q.delete();
            for (int i = 0; i < int'(vecs[v].nexp); i++) sb_q.push_back(exp_ch0[vecs[v].seq[i]]);
            start_run();
            for (int i = 0; i < int'(vecs[v].nexp); i++) begin
                wait_t0(sv);
                if (vecs[v].chk_valid)
                    chk($sformatf("v%0d_valid_at_t0_%0d", v, i), 64'(sv),
                        64'(LOOP || (i != int'(vecs[v].nexp) - 1)));
                exp_pair = sb_q.pop_front();
                chk($sformatf("v%0d_gen_ch0_p%0d", v, i), gen_pairs[0], exp_pair);
                chk($sformatf("v%0d_done_p%0d", v, i), 64'(done),
                    64'(!LOOP && (i == int'(vecs[v].nexp) - 1)));
            end
        end

        // Write to the active protocol while it runs.
        run = 1'b0;
        tick(2);
        cfg_nprot = 3'd1;
        wr_rep(0, 3);
        start_run();
        wait_t0(sv);
        chk("wr_run_p1_ch3", gen_pairs[3], exp_ch3[0]);
        wr_pair(0, 3, pr(200, 1));
        chk("wr_run_out_held", pairs[3], exp_ch3[0]);
        wait_t0(sv);
        chk("wr_run_p2_ch3", gen_pairs[3], exp_ch3[0]);
        wait_t0(sv);
        chk("wr_run_p3_ch3", gen_pairs[3], exp_ch3[0]);
        run = 1'b0;
        tick(2);
        start_run();
        wait_t0(sv);
        chk("wr_run_reload_ch3", gen_pairs[3], pr(200, 1));
        run = 1'b0;
        tick(2);
        wr_pair(0, 3, exp_ch3[0]);

        // Abort in RUN at period 1 of rep 5.
        wr_rep(0, 5);
        start_run();
        wait_t0(sv);
        chk("abort_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_index", 64'(pindex), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 2 * INTERVAL; i++) begin
            @(negedge clk);
            if (valid) any_valid = 1'b1;
        end
        chk("abort_no_load", 64'(any_valid), 64'd0);
        run = 1'b1;
        @(negedge clk);
        chk("restart_valid", 64'(valid), 64'd1);
        chk("restart_index", 64'(pindex), 64'd0);
        chk("restart_pair0", pairs[0], exp_ch0[0]);
        run = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
